coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
Fare-collection stage directly upstream of the turnstile FSM. It accepts coin events, accumulates credit, and emits the one-cycle coin/paid pulse that drives the turnstile's C input once the fare is reached. It returns change and cancel refunds, and rejects coins while a paid passage is pending.

Parameters:
FARE, 25, fare in cents; must be greater than or equal to 1.
VAL_NICKEL, 5, value of coin_type 2'b01.
VAL_DIME, 10, value of coin_type 2'b10.
VAL_QUARTER, 25, value of coin_type 2'b11.
CREDIT_W, 6, credit/change width; must hold FARE-1+max coin value (49 at the defaults).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
coin_valid  input  1  one-cycle strobe: a coin was inserted.
coin_type  input  2  coin code, sampled when coin_valid=1; 2'b00 is an invalid or slug coin.
cancel  input  1  one-cycle strobe: return all credit.
gate_unlocked  input  1  turnstile state (its y output); 1 means unlocked.
fare_paid  output  1  one-cycle pulse; drives the turnstile's C input.
credit  output  CREDIT_W  current accumulated credit.
change_valid  output  1  one-cycle pulse; change_amt is valid.
change_amt  output  CREDIT_W  amount to return; holds its last value when change_valid=0.
coin_reject  output  1  one-cycle pulse; the coin was returned unaccepted.
busy  output  1  1 while in WAIT_PASS.

Behaviour:
- Reset: asserting reset (low) immediately forces state=IDLE and drives every output to 0. This applies mid-operation too: pending credit is discarded and no refund is issued.
- All outputs are registered. An event sampled at edge n appears on the outputs after edge n, for exactly one cycle in the case of pulses.
- Coin value decode: 01 = VAL_NICKEL, 10 = VAL_DIME, 11 = VAL_QUARTER, 00 = invalid.
- States:
  - IDLE: credit=0.
  - COLLECT: 0 < credit < FARE.
  - WAIT_PASS: fare taken; waiting for the passage to complete.
- IDLE or COLLECT, valid coin accepted. Compute sum = credit + value.
  - If sum >= FARE: pulse fare_paid, set credit=0, go to WAIT_PASS. If sum > FARE, also pulse change_valid with change_amt = sum - FARE in the same cycle.
  - Else: credit = sum; go to COLLECT.
- IDLE or COLLECT, invalid coin (type 00): pulse coin_reject; credit and state are unchanged.
- COLLECT, cancel: pulse change_valid with change_amt = credit; set credit=0; go to IDLE.
- IDLE, cancel: no effect; no zero-amount change pulse is issued.
- Coin and cancel in the same cycle: the coin is evaluated first.
  - If the coin reaches the fare, the fare wins, cancel is ignored, and the coin rule above applies.
  - Otherwise, refund credit + value (or credit alone if the coin is invalid, together with coin_reject), set credit=0, go to IDLE.
- WAIT_PASS:
  - busy=1.
  - Every coin, valid or not, pulses coin_reject.
  - cancel is ignored.
  - A sub-flag saw_unlock is set when gate_unlocked=1 is sampled.
  - Return to IDLE on the first cycle with saw_unlock=1 and gate_unlocked=0, i.e. after the person has passed.
  - saw_unlock is cleared on entry to WAIT_PASS.
- Arithmetic: sum is computed at CREDIT_W+1 bits, so there is no overflow at legal parameters. credit never equals or exceeds FARE.
- gate_unlocked only has an effect in WAIT_PASS.

Decomposition:
- Shared package turnstile_pkg:
  - coin_type_t encodings (COIN_NONE=00, NICKEL=01, DIME=10, QUARTER=11).
  - acceptor state enum (IDLE, COLLECT, WAIT_PASS).
  - default coin values and FARE constant.
- Sub-module coin_value_dec: combinational decode of coin_type to CREDIT_W value plus a valid flag. Small, but it is reused by the future bill/token front end.

Test Plan:
- Reset low mid-COLLECT with credit=15 -> all outputs 0 immediately, state IDLE; after release a dime gives credit=10, with no refund of the lost 15.
- Dime, dime, nickel (FARE=25) -> credit 10, 20, then fare_paid=1 for exactly one cycle, credit=0, change_valid=0, busy=1.
- Dime then quarter -> fare_paid and change_valid in the same cycle, change_amt=10, credit=0.
- Dime then cancel -> change_valid=1, change_amt=10, credit=0, state IDLE; cancel in IDLE gives no pulse. Coin type 00 gives coin_reject=1 with credit unchanged.
- In WAIT_PASS, insert a quarter -> coin_reject=1 with no credit. Drive gate_unlocked 0→1→0 -> busy drops the cycle after the falling edge is sampled, and a new quarter then gives fare_paid.
- Credit 15, nickel plus cancel in the same cycle -> change_amt=20, IDLE. Credit 15, dime plus cancel -> fare_paid=1, cancel ignored, WAIT_PASS.

Source files
------------

// File: rtl/turnstile_pkg.sv
// Shared types and default constants for the fare-collection front end.
// Holds the coin encodings, the acceptor state enum and the default coin
// values and fare.
package turnstile_pkg;

  // Coin codes presented on coin_type
  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    NICKEL    = 2'b01,
    DIME      = 2'b10,
    QUARTER   = 2'b11
  } coin_type_t;

  // Coin acceptor control states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COLLECT   = 2'd1,
    WAIT_PASS = 2'd2
  } acc_state_t;

  localparam int DEF_FARE        = 25;
  localparam int DEF_VAL_NICKEL  = 5;
  localparam int DEF_VAL_DIME    = 10;
  localparam int DEF_VAL_QUARTER = 25;
  localparam int DEF_CREDIT_W    = 6;

endpackage

// File: rtl/coin_value_dec.sv
// Purpose: decode a coin code into its credit value and a valid flag.
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode.
// Ports: coin_type (code in), value (CREDIT_W credit value), valid (1 = real coin).
module coin_value_dec
  import turnstile_pkg::*;
#(
  parameter int CREDIT_W    = DEF_CREDIT_W,
  parameter int VAL_NICKEL  = DEF_VAL_NICKEL,
  parameter int VAL_DIME    = DEF_VAL_DIME,
  parameter int VAL_QUARTER = DEF_VAL_QUARTER
) (
  input  logic [1:0]          coin_type,
  output logic [CREDIT_W-1:0] value,
  output logic                valid
);

  always_comb begin
    value = '0;
    valid = 1'b0;
    case (coin_type_t'(coin_type))
      NICKEL: begin
        value = CREDIT_W'(VAL_NICKEL);
        valid = 1'b1;
      end
      DIME: begin
        value = CREDIT_W'(VAL_DIME);
        valid = 1'b1;
      end
      QUARTER: begin
        value = CREDIT_W'(VAL_QUARTER);
        valid = 1'b1;
      end
      default: begin
        value = '0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/coin_acceptor.sv
// Purpose: accumulate coin credit, pulse fare_paid to the turnstile, refund change/cancel.
// Latency: one cycle; an event sampled at edge n shows on the registered outputs after edge n.
// Backpressure: none; coins arriving while a passage is pending are returned via coin_reject.
// Ports: clk, reset (async active-low); coin_valid/coin_type, cancel, gate_unlocked in;
//        fare_paid, credit, change_valid/change_amt, coin_reject, busy out (all registered).
module coin_acceptor
  import turnstile_pkg::*;
#(
  parameter int FARE        = DEF_FARE,
  parameter int VAL_NICKEL  = DEF_VAL_NICKEL,
  parameter int VAL_DIME    = DEF_VAL_DIME,
  parameter int VAL_QUARTER = DEF_VAL_QUARTER,
  parameter int CREDIT_W    = DEF_CREDIT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                cancel,
  input  logic                gate_unlocked,
  output logic                fare_paid,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic                coin_reject,
  output logic                busy
);

  // Fare at the widened sum width so compares and subtraction never wrap
  localparam logic [CREDIT_W:0] FARE_X = (CREDIT_W+1)'(FARE);

  acc_state_t            state, state_n;
  logic                  saw_unlock, saw_unlock_n;
  logic [CREDIT_W-1:0]   credit_n, change_amt_n;
  logic                  fare_paid_n, change_valid_n, coin_reject_n, busy_n;
  logic [CREDIT_W-1:0]   coin_val;
  logic                  coin_ok;
  logic [CREDIT_W:0]     sum;

  coin_value_dec #(
    .CREDIT_W    (CREDIT_W),
    .VAL_NICKEL  (VAL_NICKEL),
    .VAL_DIME    (VAL_DIME),
    .VAL_QUARTER (VAL_QUARTER)
  ) u_dec (
    .coin_type (coin_type),
    .value     (coin_val),
    .valid     (coin_ok)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      saw_unlock   <= 1'b0;
      credit       <= '0;
      change_amt   <= '0;
      fare_paid    <= 1'b0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      saw_unlock   <= saw_unlock_n;
      credit       <= credit_n;
      change_amt   <= change_amt_n;
      fare_paid    <= fare_paid_n;
      change_valid <= change_valid_n;
      coin_reject  <= coin_reject_n;
      busy         <= busy_n;
    end
  end

  always_comb begin
    state_n        = state;
    saw_unlock_n   = saw_unlock;
    credit_n       = credit;
    change_amt_n   = change_amt;   // holds between change pulses
    fare_paid_n    = 1'b0;
    change_valid_n = 1'b0;
    coin_reject_n  = 1'b0;
    sum            = {1'b0, credit} + {1'b0, coin_val};

    case (state)
      IDLE, COLLECT: begin
        if (coin_valid && coin_ok && (sum >= FARE_X)) begin
          // Reaching the fare takes priority over a simultaneous cancel
          fare_paid_n  = 1'b1;
          credit_n     = '0;
          state_n      = WAIT_PASS;
          saw_unlock_n = 1'b0;
          if (sum > FARE_X) begin
            change_valid_n = 1'b1;
            change_amt_n   = CREDIT_W'(sum - FARE_X);
          end
        end else if (coin_valid && coin_ok) begin
          if (cancel) begin
            // Coin counted first, then everything refunded
            change_valid_n = 1'b1;
            change_amt_n   = sum[CREDIT_W-1:0];
            credit_n       = '0;
            state_n        = IDLE;
          end else begin
            credit_n = sum[CREDIT_W-1:0];
            state_n  = COLLECT;
          end
        end else begin
          coin_reject_n = coin_valid;
          // Zero credit means IDLE: cancel there must not emit an empty refund
          if (cancel && (credit != '0)) begin
            change_valid_n = 1'b1;
            change_amt_n   = credit;
            credit_n       = '0;
            state_n        = IDLE;
          end
        end
      end

      WAIT_PASS: begin
        coin_reject_n = coin_valid;
        // Leave only once the gate has opened and closed again
        if (saw_unlock && !gate_unlocked) begin
          state_n = IDLE;
        end else if (gate_unlocked) begin
          saw_unlock_n = 1'b1;
        end
      end

      default: begin
        state_n  = IDLE;
        credit_n = '0;
      end
    endcase

    busy_n = (state_n == WAIT_PASS);
  end

endmodule
